// File: rtl/game_end_overlay_pkg.sv
// game_end_overlay_pkg: shared types, overlay modes and colour helper for the end-of-game overlay
package game_end_overlay_pkg;

    typedef enum logic [1:0] {IDLE, BLINK_ON, BLINK_OFF, HOLD} end_state_t;
    typedef enum logic {RES_WIN, RES_LOSE} end_result_t;

    localparam int OVL_FULL  = 0;
    localparam int OVL_BOX   = 1;
    localparam int OVL_BLEND = 2;

    // per-channel average of two 12-bit colours, 5-bit sum, truncated
    function automatic logic [11:0] blend_rgb(input logic [11:0] a, input logic [11:0] b);
        logic [11:0] r;
        r = '0;
        for (int i = 0; i < 3; i++)
            r[4*i +: 4] = 4'(({1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]}) >> 1);
        return r;
    endfunction

endpackage

// File: rtl/vga_if.sv
// vga_if: VGA timing and colour bundle passed between pipeline stages
//   vcount/hcount : line and pixel counters
//   vsync/hsync   : sync pulses
//   vblnk/hblnk   : blanking flags
//   rgb           : 12-bit colour (4 bits per channel)
interface vga_if;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;

    modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
    modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/frame_tick_gen.sv
// frame_tick_gen: one-cycle pulse on the rising edge of vblnk, marking the start of each frame
//   clk60MHz : pixel clock
//   rst_n    : asynchronous active-low reset
//   vblnk    : vertical blanking flag
//   tick     : high for the first cycle of vertical blanking
module frame_tick_gen (
    input  logic clk60MHz,
    input  logic rst_n,
    input  logic vblnk,
    output logic tick
);

    logic vblnk_d;

    always_ff @(posedge clk60MHz or negedge rst_n)
        if (!rst_n) vblnk_d <= 1'b0;
        else vblnk_d <= vblnk;

    assign tick = vblnk & ~vblnk_d;

endmodule

// File: rtl/game_end_overlay.sv
// game_end_overlay: blinks then holds a win/lose overlay on the VGA stream, 1-cycle pipeline stage
//   clk60MHz : pixel clock
//   rst_n    : asynchronous active-low reset
//   win      : level, game won (sampled in IDLE, has priority over loose)
//   loose    : level, game lost (sampled in IDLE)
//   clear    : pulse, abandon the overlay and return to IDLE
//   in       : upstream timing and colour
//   out      : downstream timing and colour, delayed one cycle
//   done     : high while the overlay is in its steady hold
module game_end_overlay
    import game_end_overlay_pkg::*;
#(
    parameter int          BLINK_FRAMES = 15,
    parameter int          NUM_BLINKS   = 3,
    parameter logic [11:0] WIN_RGB      = 12'h0F0,
    parameter logic [11:0] LOOSE_RGB    = 12'hF00,
    parameter int          MODE         = OVL_FULL,
    parameter int          BOX_X        = 312,
    parameter int          BOX_Y        = 284,
    parameter int          BOX_W        = 400,
    parameter int          BOX_H        = 200
) (
    input  logic clk60MHz,
    input  logic rst_n,
    input  logic win,
    input  logic loose,
    input  logic clear,
    vga_if.in    in,
    vga_if.out   out,
    output logic done
);

    if (BOX_X + BOX_W > 4095 || BOX_Y + BOX_H > 4095) begin : g_box_range
        $error("overlay box exceeds 12-bit coordinate range");
    end
    if (BLINK_FRAMES < 1 || BLINK_FRAMES > 255 || NUM_BLINKS < 1 || NUM_BLINKS > 15) begin : g_blink_range
        $error("BLINK_FRAMES or NUM_BLINKS out of range");
    end

    localparam logic [7:0]  FRAME_LAST = 8'(BLINK_FRAMES - 1);
    localparam logic [3:0]  BLINKS     = 4'(NUM_BLINKS);
    localparam logic [11:0] BX0        = 12'(BOX_X);
    localparam logic [11:0] BX1        = 12'(BOX_X + BOX_W);
    localparam logic [11:0] BY0        = 12'(BOX_Y);
    localparam logic [11:0] BY1        = 12'(BOX_Y + BOX_H);

    end_state_t  state, state_nxt;
    end_result_t result, result_nxt;
    logic [7:0]  frame_cnt, frame_nxt;
    logic [3:0]  blink_cnt, blink_nxt;
    logic        pending, pending_nxt;
    logic        frame_tick;
    logic        overlay;
    logic        in_box;
    logic [11:0] colour;
    logic [11:0] rgb_nxt;

    frame_tick_gen u_tick (
        .clk60MHz(clk60MHz),
        .rst_n   (rst_n),
        .vblnk   (in.vblnk),
        .tick    (frame_tick)
    );

    always_comb begin
        state_nxt   = state;
        result_nxt  = result;
        frame_nxt   = frame_cnt;
        blink_nxt   = blink_cnt;
        pending_nxt = pending;
        if (clear) begin
            state_nxt   = IDLE;
            frame_nxt   = '0;
            blink_nxt   = '0;
            pending_nxt = 1'b0;
        end else if (state == IDLE) begin
            if (win | loose) begin
                pending_nxt = 1'b1;
                result_nxt  = win ? RES_WIN : RES_LOSE;
            end
            if (frame_tick && pending) begin
                state_nxt   = BLINK_ON;
                pending_nxt = 1'b0;
                frame_nxt   = '0;
                blink_nxt   = '0;
            end
        end else if (frame_tick && state != HOLD) begin
            if (frame_cnt == FRAME_LAST) begin
                frame_nxt = '0;
                if (state == BLINK_OFF) state_nxt = BLINK_ON;
                else begin
                    // only ON phases are counted as blinks
                    blink_nxt = blink_cnt + 4'd1;
                    state_nxt = (blink_cnt + 4'd1 == BLINKS) ? HOLD : BLINK_OFF;
                end
            end else frame_nxt = frame_cnt + 8'd1;
        end
    end

    assign overlay = state == BLINK_ON || state == HOLD;
    assign colour  = result == RES_WIN ? WIN_RGB : LOOSE_RGB;
    assign in_box  = {1'b0, in.hcount} >= BX0 && {1'b0, in.hcount} < BX1 &&
                     {1'b0, in.vcount} >= BY0 && {1'b0, in.vcount} < BY1;
    assign rgb_nxt = (in.vblnk | in.hblnk) ? 12'h000 :
                     !overlay              ? in.rgb :
                     MODE == OVL_FULL      ? colour :
                     MODE == OVL_BOX       ? (in_box ? colour : in.rgb) :
                                             blend_rgb(in.rgb, colour);

    always_ff @(posedge clk60MHz or negedge rst_n)
        if (!rst_n) begin
            state      <= IDLE;
            result     <= RES_WIN;
            frame_cnt  <= '0;
            blink_cnt  <= '0;
            pending    <= 1'b0;
            done       <= 1'b0;
            out.vcount <= '0;
            out.vsync  <= 1'b0;
            out.vblnk  <= 1'b0;
            out.hcount <= '0;
            out.hsync  <= 1'b0;
            out.hblnk  <= 1'b0;
            out.rgb    <= '0;
        end else begin
            state      <= state_nxt;
            result     <= result_nxt;
            frame_cnt  <= frame_nxt;
            blink_cnt  <= blink_nxt;
            pending    <= pending_nxt;
            done       <= state == HOLD;
            out.vcount <= in.vcount;
            out.vsync  <= in.vsync;
            out.vblnk  <= in.vblnk;
            out.hcount <= in.hcount;
            out.hsync  <= in.hsync;
            out.hblnk  <= in.hblnk;
            out.rgb    <= rgb_nxt;
        end

endmodule

// File: tb/tb_game_end_overlay.sv
// tb_game_end_overlay: scoreboard bench for three overlay modes driven by a shared random VGA stream
module tb_game_end_overlay;

    localparam int FL = 40;
    localparam int VB = 34;
    localparam int MD[3] = '{0, 1, 2};
    localparam int BF[3] = '{2, 2, 1};
    localparam int NB[3] = '{2, 2, 3};
    localparam int HC[10] = '{0, 311, 312, 313, 500, 710, 711, 712, 1000, 2047};
    localparam int VC[9] = '{0, 283, 284, 285, 400, 482, 483, 484, 700};

    typedef struct packed {
        logic [2:0][11:0] rgb;
        logic [2:0]       d;
        logic [25:0]      tim;
    } exp_t;

    logic clk60MHz = 0, rst_n = 0, win = 0, loose = 0, clear = 0;
    logic done0, done1, done2;
    int   errors = 0, checks = 0, fc = 0;
    exp_t q[$];
    exp_t e;
    int   m_ticks[3];
    bit   m_pend[3], m_res[3];
    bit   prev_vb = 0;

    vga_if vin();
    vga_if vo0();
    vga_if vo1();
    vga_if vo2();

    always #5 clk60MHz = ~clk60MHz;

    game_end_overlay #(.BLINK_FRAMES(2), .NUM_BLINKS(2), .MODE(0)) dut0 (
        .clk60MHz(clk60MHz), .rst_n(rst_n), .win(win), .loose(loose), .clear(clear),
        .in(vin), .out(vo0), .done(done0));
    game_end_overlay #(.BLINK_FRAMES(2), .NUM_BLINKS(2), .MODE(1)) dut1 (
        .clk60MHz(clk60MHz), .rst_n(rst_n), .win(win), .loose(loose), .clear(clear),
        .in(vin), .out(vo1), .done(done1));
    game_end_overlay #(.BLINK_FRAMES(1), .NUM_BLINKS(3), .MODE(2)) dut2 (
        .clk60MHz(clk60MHz), .rst_n(rst_n), .win(win), .loose(loose), .clear(clear),
        .in(vin), .out(vo2), .done(done2));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // phase index since the overlay started; even phases and everything past the last blink show colour
    function automatic bit m_hold(int i);
        return m_ticks[i] >= 0 && m_ticks[i] / BF[i] >= 2 * NB[i] - 1;
    endfunction

    function automatic bit m_on(int i);
        return m_ticks[i] >= 0 && (m_hold(i) || (m_ticks[i] / BF[i]) % 2 == 0);
    endfunction

    function automatic logic [11:0] m_rgb(int i);
        int c, r;
        bit box;
        if (vin.vblnk || vin.hblnk) return 12'h000;
        if (!m_on(i)) return vin.rgb;
        c = m_res[i] ? 'hF00 : 'h0F0;
        box = vin.hcount >= 312 && vin.hcount < 712 && vin.vcount >= 284 && vin.vcount < 484;
        if (MD[i] == 0) return 12'(c);
        if (MD[i] == 1) return box ? 12'(c) : vin.rgb;
        r = 0;
        for (int k = 0; k < 3; k++)
            r += ((((int'(vin.rgb) >> (4 * k)) & 15) + ((c >> (4 * k)) & 15)) / 2) << (4 * k);
        return 12'(r);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_ticks[i] = -1;
            m_pend[i]  = 0;
            m_res[i]   = 0;
        end
        prev_vb = 0;
    endtask

    task automatic step(input logic w, input logic l, input logic c);
        exp_t x;
        bit tick, old;
        @(negedge clk60MHz);
        #1;
        win = w;
        loose = l;
        clear = c;
        vin.vblnk  = fc >= VB;
        vin.hblnk  = fc % 8 == 7;
        vin.hcount = $urandom_range(0, 3) == 0 ? 11'($urandom_range(0, 2047)) : 11'(HC[$urandom_range(0, 9)]);
        vin.vcount = 11'(VC[$urandom_range(0, 8)]);
        vin.hsync  = 1'($urandom_range(0, 1));
        vin.vsync  = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
            0: vin.rgb = 12'h123;
            1: vin.rgb = 12'h0FF;
            default: vin.rgb = 12'($urandom);
        endcase
        tick = vin.vblnk && !prev_vb;
        x.tim = {vin.vcount, vin.vsync, vin.vblnk, vin.hcount, vin.hsync, vin.hblnk};
        for (int i = 0; i < 3; i++) begin
            x.rgb[i] = m_rgb(i);
            x.d[i]   = m_hold(i);
            if (c) begin
                m_ticks[i] = -1;
                m_pend[i]  = 0;
            end else if (m_ticks[i] < 0) begin
                old = m_pend[i];
                if (w || l) begin
                    m_pend[i] = 1;
                    m_res[i]  = !w;
                end
                if (tick && old) begin
                    m_ticks[i] = 0;
                    m_pend[i]  = 0;
                end
            end else if (tick && m_ticks[i] < 10000) m_ticks[i]++;
        end
        q.push_back(x);
        prev_vb = vin.vblnk;
        fc = (fc + 1) % FL;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0);
    endtask

    task automatic goto_fc(input int k);
        while (fc != k) step(0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk60MHz);
        #1;
        rst_n = 0;
        win = 0;
        loose = 0;
        clear = 0;
        vin.vblnk = 0;
        vin.hblnk = 0;
        #1;
        chk("rst_rgb0", 32'(vo0.rgb), 0);
        chk("rst_rgb1", 32'(vo1.rgb), 0);
        chk("rst_rgb2", 32'(vo2.rgb), 0);
        chk("rst_tim0", 32'({vo0.vcount, vo0.vsync, vo0.vblnk, vo0.hcount, vo0.hsync, vo0.hblnk}), 0);
        chk("rst_done", 32'({done0, done1, done2}), 0);
        repeat (2) @(negedge clk60MHz);
        #1 rst_n = 1;
        model_reset();
    endtask

    always @(negedge clk60MHz)
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("rgb0", 32'(vo0.rgb), 32'(e.rgb[0]));
            chk("rgb1", 32'(vo1.rgb), 32'(e.rgb[1]));
            chk("rgb2", 32'(vo2.rgb), 32'(e.rgb[2]));
            chk("done0", 32'(done0), 32'(e.d[0]));
            chk("done1", 32'(done1), 32'(e.d[1]));
            chk("done2", 32'(done2), 32'(e.d[2]));
            chk("tim0", 32'({vo0.vcount, vo0.vsync, vo0.vblnk, vo0.hcount, vo0.hsync, vo0.hblnk}), 32'(e.tim));
            chk("tim1", 32'({vo1.vcount, vo1.vsync, vo1.vblnk, vo1.hcount, vo1.hsync, vo1.hblnk}), 32'(e.tim));
            chk("tim2", 32'({vo2.vcount, vo2.vsync, vo2.vblnk, vo2.hcount, vo2.hsync, vo2.hblnk}), 32'(e.tim));
        end

    initial begin
        vin.vcount = 0;
        vin.vsync  = 0;
        vin.vblnk  = 0;
        vin.hcount = 0;
        vin.hsync  = 0;
        vin.hblnk  = 0;
        vin.rgb    = 0;
        model_reset();
        do_reset();
        run(3 * FL);
        goto_fc(17);
        step(1, 0, 0);
        run(14 * FL);
        step(0, 0, 1);
        run(FL);
        step(1, 1, 0);
        run(3 * FL);
        step(0, 1, 0);
        run(12 * FL);
        step(0, 0, 1);
        run(5);
        step(0, 1, 0);
        run(14 * FL);
        step(0, 0, 1);
        step(1, 0, 0);
        goto_fc(VB);
        step(0, 0, 0);
        goto_fc(VB);
        step(0, 0, 0);
        goto_fc(VB);
        step(0, 0, 0);
        goto_fc(VB);
        step(0, 0, 1);
        run(3 * FL);
        for (int k = 0; k < 40 * FL; k++)
            step($urandom_range(0, 299) == 0, $urandom_range(0, 299) == 0, $urandom_range(0, 1499) == 0);
        step(0, 0, 1);
        step(0, 1, 0);
        goto_fc(VB);
        step(0, 0, 0);
        run(5);
        do_reset();
        run(3 * FL);
        @(negedge clk60MHz);
        #1;
        chk("queue_drained", 32'(q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/game_end_overlay.md
Name: game_end_overlay

Overview:
- Pipelined VGA overlay stage that signals end of game (win or lose) on the video stream.
- Successor to the fixed solid-colour end screen; adds:
  - a frame-synchronised blink sequence followed by a steady hold;
  - selectable full-screen, boxed or 50 % blended overlay;
  - parametrised colours and timing;
  - a clear input and a done status.
- Sits in the vga_if chain after the sprite/background stages, before the VGA output registers.

Parameters:
- BLINK_FRAMES, 15, frames per blink phase (on or off); legal range 1..255
- NUM_BLINKS, 3, number of ON phases before HOLD; legal range 1..15
- WIN_RGB, 12'h0F0, overlay colour for win
- LOOSE_RGB, 12'hF00, overlay colour for lose
- MODE, 0, 0 = full screen, 1 = box only, 2 = 50 % blend over full screen
- BOX_X, 312, box left hcount (MODE 1)
- BOX_Y, 284, box top vcount (MODE 1)
- BOX_W, 400, box width in pixels
- BOX_H, 200, box height in lines

Ports:
- clk60MHz  input  1  pixel clock
- rst_n  input  1  asynchronous active-low reset
- win  input  1  level; game won
- loose  input  1  level; game lost
- clear  input  1  single-cycle pulse; abort/finish overlay and return to IDLE
- in  vga_if.in  -  upstream timing and rgb
- out  vga_if.out  -  downstream timing and rgb, 1-cycle delayed
- done  output  1  high while in HOLD

Behaviour:
- Reset (async, rst_n = 0):
  - all out.* fields = 0; done = 0; state = IDLE; counters = 0; pending = 0; result = 0; vblnk_d = 0.
- Pipeline latency: exactly 1 clk60MHz cycle for vcount, vsync, vblnk, hcount, hsync, hblnk and rgb.
- Frame tick: frame_tick = in.vblnk & ~vblnk_d, where vblnk_d is in.vblnk registered one cycle. All state transitions except clear occur only on frame_tick, so there is no mid-frame tearing.
- Result latch, IDLE only:
  - If win | loose, set pending = 1 and result = WIN if win, else LOSE.
  - win has priority when both are high.
  - Inputs are ignored outside IDLE.
- FSM states: IDLE, BLINK_ON, BLINK_OFF, HOLD.
  - IDLE -> BLINK_ON on frame_tick when pending. Clear pending, frame_cnt = 0, blink_cnt = 0.
  - BLINK_ON:
    - frame_cnt increments on each frame_tick.
    - When frame_cnt == BLINK_FRAMES-1 on a tick: frame_cnt = 0, blink_cnt += 1.
    - Go to HOLD if blink_cnt+1 == NUM_BLINKS, otherwise BLINK_OFF.
  - BLINK_OFF: same counting; on the final tick of the phase -> BLINK_ON.
  - HOLD: stays until clear.
  - clear, any state: next cycle state = IDLE, pending = 0, counters = 0. clear has priority over a simultaneous frame_tick and over simultaneous win/loose.
- Overlay active when state ∈ {BLINK_ON, HOLD}.
  - Colour C = WIN_RGB if result = WIN, else LOSE_RGB.
- rgb_nxt, priority order:
  1. in.vblnk | in.hblnk -> 12'h000.
  2. Overlay inactive -> in.rgb.
  3. MODE 0 -> C.
  4. MODE 1 -> C if BOX_X <= hcount < BOX_X+BOX_W and BOX_Y <= vcount < BOX_Y+BOX_H, otherwise in.rgb.
  5. MODE 2 -> per 4-bit channel (in.ch + C.ch) >> 1, computed in 5-bit, truncated result, no rounding.
- Box bounds are computed in 12-bit unsigned. BOX_X+BOX_W and BOX_Y+BOX_H must not exceed 4095 (elaboration assertion).
- done = registered (state == HOLD); asserts the cycle after HOLD is entered.
- Reset mid-sequence: immediate return to the reset values above. The output stream shows 0 rgb until the first post-reset cycle.

Decomposition:
- variable_pkg gains:
  - typedef enum logic [1:0] {IDLE, BLINK_ON, BLINK_OFF, HOLD} end_state_t;
  - typedef enum logic {RES_WIN, RES_LOSE} end_result_t;
  - localparams OVL_FULL = 0, OVL_BOX = 1, OVL_BLEND = 2.
- One sub-module, frame_tick_gen: vblnk edge detector with async active-low reset. It is reusable by other frame-timed stages.

Test Plan:
- Reset release, no win/loose, ramp in.rgb -> out equals in delayed 1 cycle; out.rgb = 0 during blanking; done = 0.
- BLINK_FRAMES=2, NUM_BLINKS=2, MODE 0; pulse win mid-frame 5:
  - overlay 0F0 starts at frame 6 tick;
  - phases: ON frames 6–7, OFF 8–9, ON 10–11;
  - HOLD from frame 12; done rises 1 cycle after the frame-12 tick.
- win and loose both high in IDLE -> result WIN (0F0); a later loose pulse during BLINK is ignored.
- MODE 1, box 312/284/400/200:
  - in.rgb = 123 in HOLD -> out 0F0 at (312,284) and (711,483);
  - out 123 at (311,284) and (712,483).
- MODE 2, LOSE, in.rgb = 0FF in HOLD -> out.rgb = 777 (channels (0+F)>>1 = 7, (F+0)>>1 = 7, (F+0)>>1 = 7).
- clear asserted in BLINK_OFF on the same cycle as frame_tick -> IDLE next cycle; no overlay; done = 0. An async rst_n pulse mid-BLINK_ON clears all outputs within the same cycle.
